// File: rtl/shared_div_sequencer.sv
// Shared radix-2 restoring divider: arbitrates two requesters onto one XLEN-step divide loop.
// Latency: XLEN cycles from request accept to rsp_valid_o; one idle cycle between operations.
// Backpressure: request ready only in IDLE; result held in DONE until the owner's rsp_ready_i.
module shared_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [3:0]        req_op_i,
  input  logic [2*XLEN-1:0] req_a_i,
  input  logic [2*XLEN-1:0] req_b_i,
  input  logic [1:0]        flush_i,
  output logic [1:0]        rsp_valid_o,
  input  logic [1:0]        rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              busy_o,
  output logic              owner_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [XLEN-1:0]     r_dividend;
  logic [2*XLEN-2:0]   r_divisor;
  logic [XLEN-1:0]     r_quotient;
  logic [XLEN-1:0]     r_qmask;
  logic                r_sign;
  logic                r_is_rem;
  logic                r_owner;
  logic                r_last_grant;

  logic [1:0]          w_elig;
  logic [1:0]          w_grant;
  logic                w_accept;
  logic                w_sel;
  logic [1:0]          w_op;
  logic [XLEN-1:0]     w_a;
  logic [XLEN-1:0]     w_b;
  logic                w_signed;
  logic [XLEN-1:0]     w_a_abs;
  logic [XLEN-1:0]     w_b_abs;
  logic                w_sign_in;
  logic                w_fits;
  logic                w_owner_flush;
  logic                w_rsp_vld;
  logic [XLEN-1:0]     w_result;

  // Round-robin grant among valid, non-flushed requesters; ties go to the port not served last.
  always_comb begin
    w_elig  = req_valid_i & ~flush_i;
    w_grant = w_elig;
    if (w_elig == 2'b11) begin
      w_grant = r_last_grant ? 2'b01 : 2'b10;
    end
  end

  assign req_ready_o = (r_state == S_IDLE) ? w_grant : 2'b00;
  assign w_accept    = |req_ready_o;
  assign w_sel       = w_grant[1];
  assign w_op        = w_sel ? req_op_i[3:2] : req_op_i[1:0];
  assign w_a         = w_sel ? req_a_i[2*XLEN-1:XLEN] : req_a_i[XLEN-1:0];
  assign w_b         = w_sel ? req_b_i[2*XLEN-1:XLEN] : req_b_i[XLEN-1:0];

  // Signed ops divide magnitudes; the sign is re-applied to the result in DONE.
  // DIV by zero keeps the quotient positive so it stays all ones; REM follows the dividend.
  always_comb begin
    w_signed  = ~w_op[0];
    w_a_abs   = (w_signed & w_a[XLEN-1]) ? -w_a : w_a;
    w_b_abs   = (w_signed & w_b[XLEN-1]) ? -w_b : w_b;
    w_sign_in = 1'b0;
    if (w_signed) begin
      if (w_op[1]) begin
        w_sign_in = w_a[XLEN-1];
      end else begin
        w_sign_in = (w_a[XLEN-1] ^ w_b[XLEN-1]) & (w_b != '0);
      end
    end
  end

  assign w_fits        = r_divisor <= {{(XLEN-1){1'b0}}, r_dividend};
  assign w_owner_flush = flush_i[r_owner];

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: accept in IDLE, step until the last quotient bit, hold result until consumed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (w_owner_flush)   w_next = S_IDLE;
        else if (r_qmask[0]) w_next = S_DONE;
      end
      S_DONE: begin
        if (w_owner_flush || rsp_ready_i[r_owner]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: load operands on accept, one restoring step per cycle while BUSY.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_quotient   <= '0;
      r_qmask      <= '0;
      r_sign       <= 1'b0;
      r_is_rem     <= 1'b0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_dividend   <= w_a_abs;
      r_divisor    <= {w_b_abs, {(XLEN-1){1'b0}}};
      r_quotient   <= '0;
      r_qmask      <= {1'b1, {(XLEN-1){1'b0}}};
      r_sign       <= w_sign_in;
      r_is_rem     <= w_op[1];
      r_owner      <= w_sel;
      r_last_grant <= w_sel;
    end else if (r_state == S_BUSY) begin
      if (w_fits) begin
        r_dividend <= r_dividend - r_divisor[XLEN-1:0];
        r_quotient <= r_quotient | r_qmask;
      end
      r_divisor <= r_divisor >> 1;
      r_qmask   <= r_qmask >> 1;
    end
  end

  // Result select and sign fixup; a flush in DONE suppresses the response in that same cycle.
  always_comb begin
    w_result  = r_is_rem ? (r_sign ? -r_dividend : r_dividend)
                         : (r_sign ? -r_quotient : r_quotient);
    w_rsp_vld = (r_state == S_DONE) & ~w_owner_flush;
  end

  assign rsp_valid_o = {w_rsp_vld & r_owner, w_rsp_vld & ~r_owner};
  assign rsp_data_o  = (r_state == S_DONE) ? w_result : '0;
  assign busy_o      = (r_state != S_IDLE);
  assign owner_o     = r_owner;

endmodule

// File: tb/tb_shared_div_sequencer.sv
// Bench for shared_div_sequencer: directed and randomized divides against an arithmetic reference.
// Checks latency, arbitration, backpressure, flush and asynchronous reset behaviour.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_shared_div_sequencer;
  localparam int XLEN = 32;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [3:0]        req_op_i;
  logic [2*XLEN-1:0] req_a_i;
  logic [2*XLEN-1:0] req_b_i;
  logic [1:0]        flush_i;
  logic [1:0]        rsp_valid_o;
  logic [1:0]        rsp_ready_i;
  logic [XLEN-1:0]   rsp_data_o;
  logic              busy_o;
  logic              owner_o;

  int checks   = 0;
  int failures = 0;

  logic [1:0]  t_op [2];
  logic [31:0] t_a  [2];
  logic [31:0] t_b  [2];

  shared_div_sequencer #(.XLEN(XLEN)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .flush_i     (flush_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .busy_o      (busy_o),
    .owner_o     (owner_o)
  );

  always #5 clk_i = ~clk_i;

  // RV32M result semantics, computed directly with language arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      2'b01:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   model = (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input int p, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    t_op[p] = op;
    t_a[p]  = a;
    t_b[p]  = b;
    req_op_i[2*p +: 2]  = op;
    req_a_i[32*p +: 32] = a;
    req_b_i[32*p +: 32] = b;
    req_valid_i[p]      = 1'b1;
    #1;
  endtask

  // Accept port p's presented request, check latency and result, apply bp cycles of backpressure.
  task automatic run_op(input int p, input int bp);
    int          n;
    logic [1:0]  onehot;
    logic [31:0] exp;
    onehot = 2'b01 << p;
    n = 0;
    while (req_ready_o[p] !== 1'b1 && n < 80) begin
      tick();
      n++;
    end
    chk($sformatf("grant_p%0d", p), req_ready_o, onehot);
    if (req_ready_o !== onehot) begin
      req_valid_i[p] = 1'b0;
      return;
    end
    exp = model(t_op[p], t_a[p], t_b[p]);
    tick();
    req_valid_i[p] = 1'b0;
    chk("busy_after_accept", busy_o, 1'b1);
    n = 0;
    while (rsp_valid_o === 2'b00 && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, 32);
    chk($sformatf("rsp_valid_p%0d", p), rsp_valid_o, onehot);
    chk("owner", owner_o, p[0]);
    chk($sformatf("data op%0d a=%h b=%h", t_op[p], t_a[p], t_b[p]), rsp_data_o, exp);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_valid_hold", rsp_valid_o, onehot);
      chk("bp_data_hold", rsp_data_o, exp);
    end
    rsp_ready_i[p] = 1'b1;
    tick();
    rsp_ready_i[p] = 1'b0;
    #1;
    chk("idle_after_rsp", busy_o, 1'b0);
    chk("no_valid_after_rsp", rsp_valid_o, 2'b00);
  endtask

  initial begin
    int n;
    reset_i     = 1'b1;
    req_valid_i = 2'b00;
    req_op_i    = '0;
    req_a_i     = '0;
    req_b_i     = '0;
    flush_i     = 2'b00;
    rsp_ready_i = 2'b00;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", rsp_valid_o, 2'b00);
    chk("rst_data", rsp_data_o, 32'h0);
    chk("rst_owner", owner_o, 1'b0);
    chk("rst_ready_none", req_ready_o, 2'b00);
    reset_i = 1'b0;

    // Simultaneous requests from reset: port 0 first, then port 1.
    present(0, 2'b01, 32'd100, 32'd7);
    present(1, 2'b00, 32'hFFFF_FFF9, 32'd2);
    chk("tie_from_reset", req_ready_o, 2'b01);
    run_op(0, 10);
    chk("second_grant", req_ready_o, 2'b10);
    run_op(1, 0);

    // Second simultaneous pair: alternation gives port 0 again.
    present(0, 2'b11, 32'd100, 32'd7);
    present(1, 2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("tie_alternate", req_ready_o, 2'b01);
    run_op(0, 0);
    run_op(1, 1);

    // Boundary results.
    present(0, 2'b01, 32'd5, 32'd0);                   run_op(0, 0);
    present(1, 2'b10, 32'd5, 32'd0);                   run_op(1, 0);
    present(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);   run_op(0, 0);
    present(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);   run_op(1, 0);
    present(0, 2'b00, 32'hFFFF_FFF9, 32'd0);           run_op(0, 0);
    present(1, 2'b10, 32'hFFFF_FFF9, 32'd0);           run_op(1, 0);

    // Randomized operations.
    for (int i = 0; i < 12; i++) begin
      int          p;
      logic [31:0] a;
      logic [31:0] b;
      p = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      present(p, 2'($urandom_range(0, 3)), a, b);
      run_op(p, $urandom_range(0, 2));
    end

    // Flush the owner during BUSY with the other port waiting.
    present(0, 2'b01, 32'd1000, 32'd3);
    chk("flush_setup_grant", req_ready_o, 2'b01);
    tick();
    req_valid_i[0] = 1'b0;
    present(1, 2'b01, 32'd77, 32'd7);
    chk("no_ready_while_busy", req_ready_o, 2'b00);
    repeat (9) tick();
    flush_i[0] = 1'b1;
    #1;
    chk("flush_busy_valid", rsp_valid_o, 2'b00);
    tick();
    flush_i[0] = 1'b0;
    #1;
    chk("flush_busy_idle", busy_o, 1'b0);
    chk("flush_busy_no_rsp", rsp_valid_o, 2'b00);
    chk("flush_other_granted", req_ready_o, 2'b10);
    run_op(1, 0);

    // Non-owner flush is ignored; owner flush in DONE suppresses the response.
    present(0, 2'b01, 32'd50, 32'd5);
    tick();
    req_valid_i[0] = 1'b0;
    flush_i[1] = 1'b1;
    tick();
    flush_i[1] = 1'b0;
    chk("nonowner_flush_ignored", busy_o, 1'b1);
    n = 0;
    while (rsp_valid_o === 2'b00 && n < 40) begin
      tick();
      n++;
    end
    chk("done_before_flush", rsp_valid_o, 2'b01);
    flush_i[0] = 1'b1;
    #1;
    chk("flush_done_valid", rsp_valid_o, 2'b00);
    tick();
    flush_i[0] = 1'b0;
    #1;
    chk("flush_done_idle", busy_o, 1'b0);

    // Asynchronous reset in the middle of a port 1 operation.
    present(1, 2'b00, 32'd1234, 32'd5);
    chk("pre_reset_grant", req_ready_o, 2'b10);
    tick();
    req_valid_i[1] = 1'b0;
    repeat (4) tick();
    chk("pre_reset_owner", owner_o, 1'b1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_rst_busy", busy_o, 1'b0);
    chk("async_rst_valid", rsp_valid_o, 2'b00);
    chk("async_rst_owner", owner_o, 1'b0);
    #3;
    reset_i = 1'b0;
    tick();
    present(0, 2'b01, 32'd9, 32'd3);
    present(1, 2'b01, 32'd21, 32'd4);
    chk("tie_after_reset", req_ready_o, 2'b01);
    run_op(0, 0);
    run_op(1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shared_div_sequencer.md
# shared_div_sequencer

Sequencer and two-port arbiter for one iterative radix-2 restoring divider shared by the integer execute stage (port 0, RV32M DIV/DIVU/REM/REMU) and the FPU (port 1, mantissa/integer divide). The block owns the 32-step divide FSM, operand sign conditioning and result sign fixup. Each requester gets a valid/ready request handshake and a valid/ready response handshake. It sits beside the execute stage and replaces the private per-unit divide loop, so only one divide array exists in the core.

## Interface
- XLEN, 32: operand/result width; the iteration count equals XLEN.
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  2  bit n = port n presents a request.
- req_ready_o  out  2  bit n = port n's request is accepted this cycle (the handshake occurs when valid & ready).
- req_op_i  in  4  [2n+1:2n] = port n op: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M funct3[1:0]).
- req_a_i  in  2*XLEN  [XLEN*n +: XLEN] = port n dividend.
- req_b_i  in  2*XLEN  [XLEN*n +: XLEN] = port n divisor.
- flush_i  in  2  bit n = cancel port n's outstanding or presented request.
- rsp_valid_o  out  2  bit n = result for port n is on rsp_data_o.
- rsp_ready_i  in  2  bit n = port n consumes the result.
- rsp_data_o  out  XLEN  quotient or remainder, shared by both ports.
- busy_o  out  1  the FSM is not IDLE.
- owner_o  out  1  the port owning the current or last operation.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Registers:
  - dividend (XLEN), divisor (2*XLEN-1), quotient (XLEN), qmask (XLEN)
  - sign, isRem, owner, lastGrant
- **Arbitration (IDLE only).** The eligible set is req_valid_i & ~flush_i.
  - If only one port is eligible, grant it.
  - If both are eligible, grant the port != lastGrant (round-robin).
  - req_ready_o[n] = (state==IDLE) & grant[n]. At most one bit is ever set.
  - Outside IDLE, req_ready_o = 00.
- **Accept edge.** On a handshake, the FSM loads:
  - signed op (op[0]==0): dividend = |a|, divisor = {|b|, (XLEN-1)'b0}
  - unsigned op: raw a and b are used the same way
  - quotient = 0, qmask = 1<<(XLEN-1), isRem = op[1], owner = n, lastGrant = n
  - signed DIV: sign = (a[31]^b[31]) & (b!=0)
  - signed REM: sign = a[31]
  - unsigned ops: sign = 0
  - The state moves to BUSY.
- **BUSY step.** Each edge performs one step:
  - if divisor <= {0, dividend}: dividend -= divisor[XLEN-1:0] and quotient |= qmask
  - divisor >>= 1, qmask >>= 1
  - The step in which qmask[0] is set moves the state to DONE.
- **DONE.**
  - rsp_valid_o[owner] = 1.
  - rsp_data_o = isRem ? (sign ? -dividend : dividend) : (sign ? -quotient : quotient). This is combinational from registers.
  - Both rsp_valid_o and rsp_data_o hold stable until rsp_ready_i[owner]=1. That handshake edge returns the FSM to IDLE.
  - rsp_data_o = 0 in all other states.
- **Boundary results.** These fall out of the algorithm with no special-case logic:
  - divide by zero: quotient = all ones, remainder = dividend
  - 0x80000000 / 0xFFFFFFFF (signed): quotient = 0x80000000, remainder = 0
- **Flush.** flush_i[owner] in BUSY or DONE aborts to IDLE on the next edge.
  - No response is issued; rsp_valid_o is forced to 0 in that cycle.
  - lastGrant is kept.
  - flush_i for the non-owner port has no effect outside IDLE.
- **Reset.** reset_i is asynchronous, including mid-operation. It forces:
  - state IDLE, lastGrant = 1 (so port 0 wins the first tie), owner = 0
  - all datapath registers = 0
  - Outputs after reset: rsp_valid_o = 00, rsp_data_o = 0, busy_o = 0, owner_o = 0, req_ready_o = grant-derived.

## Timing
- Handshake at edge k: BUSY steps occur on edges k+1..k+XLEN.
- rsp_valid_o is high from edge k+XLEN onward. Latency is 32 cycles for XLEN=32.
- A response handshake at edge m gives IDLE in cycle m+1.
- The next request can be accepted at edge m+1 at the earliest. This leaves one idle cycle between operations.
- busy_o is high from edge k+1 to edge m.
- Requests are not queued. A requester holds valid and operands stable until ready.

## Test plan
- **Port 0 unsigned divide.** DIVU a=100, b=7 → rsp_valid_o=01 exactly 32 cycles after accept, data=14. Repeat as REMU → data=2.
- **Signed ops.** Port 1, DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1).
- **Boundary results.**
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0
- **Arbitration.** Both ports are valid from reset → port 0 is granted first and port 1 is granted after port 0's response. A second simultaneous pair → port 0 is granted (alternation holds).
- **Backpressure and flush.**
  - rsp_ready_i held low for 10 cycles → rsp_data_o is stable and rsp_valid_o stays high.
  - flush_i[owner] at step 10 → IDLE next cycle, no rsp_valid_o pulse, and the other port is granted.
- **Asynchronous reset mid-operation.** reset_i asserted at step 5, between clock edges → busy_o=0 and rsp_valid_o=00 immediately. A new DIVU 9/3 then returns 3.
